// File: rtl/ahb_sram_bridge.sv
// rtl/ahb_sram_bridge.sv - AHB-Lite slave in front of a single-port synchronous SRAM
// Zero-wait reads/writes, byte-lane writes, one-entry posted write buffer with read forwarding.
module ahb_sram_bridge #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 16,
  parameter int ADDR_W = 32
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADYIN,
  output logic                HREADYOUT,
  output logic [1:0]          HRESP,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {RESP_OK, RESP_ERR1, RESP_ERR2} resp_t;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_PEND, BUF_FULL} buf_t;

  resp_t             resp_q, resp_d;
  buf_t              buf_q, buf_d;
  logic [MEM_AW-1:0] buf_addr;
  logic [NB-1:0]     buf_be;
  logic [DATA_W-1:0] buf_data;
  logic              rd_dp;
  logic [MEM_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;
  logic [NB-1:0]     lane_be;
  logic [MEM_AW-1:0] word_addr;
  logic              accept, illegal, misalign, out_of_range;
  logic              rd_acc, wr_acc, commit, load_buf, capture_buf, fwd;
  logic              unused_bits;

  assign unused_bits = ^HBURST;
  assign word_addr   = HADDR[LB +: MEM_AW];

  generate
    if (LB + MEM_AW < ADDR_W) begin : g_range
      assign out_of_range = |HADDR[ADDR_W-1:LB+MEM_AW];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    misalign = 1'b0;
    case (HSIZE)
      3'd1:    misalign = HADDR[0];
      3'd2:    misalign = |HADDR[1:0];
      3'd3:    misalign = |HADDR[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign illegal = ({29'd0, HSIZE} > 32'(LB)) | misalign | out_of_range;
  // The bus is stalled by us during ERR1, so nothing can be accepted then.
  assign accept  = HSEL & HREADYIN & HTRANS[1] & (resp_q != RESP_ERR1);
  assign rd_acc  = accept & ~illegal & ~HWRITE;
  assign wr_acc  = accept & ~illegal & HWRITE;
  assign commit  = ~rd_acc & (buf_q != BUF_EMPTY);

  always_comb begin
    lane_be = '0;
    for (int i = 0; i < NB; i++) begin
      lane_be[i] = (i >= int'(HADDR[LB-1:0])) && (i < int'(HADDR[LB-1:0]) + (1 << HSIZE));
    end
  end

  always_comb begin
    resp_d      = resp_q;
    buf_d       = buf_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = word_addr;
    mem_wdata   = buf_data;
    load_buf    = 1'b0;
    capture_buf = 1'b0;

    if (resp_q == RESP_ERR1) resp_d = RESP_ERR2;
    else if (accept && illegal) resp_d = RESP_ERR1;
    else resp_d = RESP_OK;

    // PEND still has its data on HWDATA this cycle; FULL already holds it.
    if (commit) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_be    = buf_be;
      mem_addr  = buf_addr;
      mem_wdata = (buf_q == BUF_FULL) ? buf_data : HWDATA;
      buf_d     = BUF_EMPTY;
    end

    if (rd_acc) begin
      mem_en = 1'b1;
      if (buf_q == BUF_PEND) begin
        capture_buf = 1'b1;
        buf_d       = BUF_FULL;
      end
    end else if (wr_acc) begin
      load_buf = 1'b1;
      buf_d    = BUF_PEND;
    end
  end

  assign fwd = rd_dp && (buf_q == BUF_FULL) && (buf_addr == rd_addr);

  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < NB; i++) begin
      if (fwd && buf_be[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      resp_q   <= RESP_OK;
      buf_q    <= BUF_EMPTY;
      buf_addr <= '0;
      buf_be   <= '0;
      buf_data <= '0;
      rd_dp    <= 1'b0;
      rd_addr  <= '0;
      rdata_q  <= '0;
    end else begin
      resp_q <= resp_d;
      buf_q  <= buf_d;
      rd_dp  <= rd_acc;
      if (load_buf) begin
        buf_addr <= word_addr;
        buf_be   <= lane_be;
      end
      if (capture_buf) buf_data <= HWDATA;
      if (rd_acc) rd_addr <= word_addr;
      if (rd_dp) rdata_q <= merged;
    end
  end

  assign HRDATA    = rd_dp ? merged : rdata_q;
  assign HREADYOUT = (resp_q != RESP_ERR1);
  assign HRESP     = (resp_q == RESP_OK) ? 2'b00 : 2'b01;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb/tb_ahb_sram_bridge.sv - self-checking bench for ahb_sram_bridge
// Directed spec scenarios followed by random traffic against a byte-level memory model.
module tb_ahb_sram_bridge;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = 4;
  localparam int DEPTH = 1 << AW;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic          HWRITE = 1'b0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic [2:0]    HBURST = 3'd0;
  logic [DW-1:0] HWDATA = '0;
  logic          HREADYIN = 1'b1;
  logic          HREADYOUT;
  logic [1:0]    HRESP;
  logic [DW-1:0] HRDATA;
  logic          mem_en, mem_we;
  logic [NB-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  ahb_sram_bridge #(.DATA_W(DW), .MEM_AW(AW), .ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .mem_en(mem_en), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 HCLK = ~HCLK;

  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            n_tests = 0;
  int            n_fail = 0;
  int            wr_commits = 0;
  logic [NB-1:0] last_be = '0;

  always @(posedge HCLK) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < NB; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_commits++;
        last_be = mem_be;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  logic        dp_rd = 1'b0;
  logic        dp_wr = 1'b0;
  logic [31:0] dp_exp = '0;
  logic [31:0] dp_wdata = '0;
  int          err_phase = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [31:0] a, input logic [2:0] sz);
    int bytes;
    if (sz > 3'd2) return 1'b0;
    bytes = 1 << sz;
    return (int'(a) % bytes == 0) && (a < NB * DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] r;
    int off;
    r = old;
    off = int'(a) % NB;
    for (int b = 0; b < NB; b++)
      if (b >= off && b < off + (1 << sz)) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One bus cycle: drive an address phase, check the data phase of the previous transfer.
  task automatic bus(input logic v, input logic w, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] d);
    logic acc;
    HREADYIN = (err_phase != 1);
    acc      = v && HREADYIN;
    HSEL     = v;
    HTRANS   = v ? 2'b10 : 2'b00;
    HWRITE   = w;
    HADDR    = a;
    HSIZE    = sz;
    HWDATA   = dp_wr ? dp_wdata : $urandom;
    @(negedge HCLK);
    chk("hreadyout", 32'(HREADYOUT), (err_phase == 1) ? 32'd0 : 32'd1);
    chk("hresp", 32'(HRESP), (err_phase != 0) ? 32'd1 : 32'd0);
    if (dp_rd) chk("hrdata", HRDATA, dp_exp);
    @(posedge HCLK);
    #1;
    dp_rd = 1'b0;
    dp_wr = 1'b0;
    err_phase = (err_phase == 1) ? 2 : 0;
    if (acc) begin
      if (!legal(a, sz)) err_phase = 1;
      else if (w) begin
        dp_wr = 1'b1;
        dp_wdata = d;
        ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, a, sz);
      end else begin
        dp_rd = 1'b1;
        dp_exp = ref_mem[a[11:2]];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
    chk({tag, "_hresp"}, 32'(HRESP), 32'd0);
    chk({tag, "_hrdata"}, HRDATA, 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
  endtask

  initial begin
    int c0, bad, r;
    logic [31:0] snap, old, a;
    logic [2:0] sz;
    logic w;

    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[32'h200 >> 2] = 32'h11223344;
    ref_mem[32'h200 >> 2] = 32'h11223344;

    #12;
    chk_reset_outputs("reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Forwarded read straight after a word write
    bus(1'b1, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
    bus(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
    idle(1);
    chk("fwd_word", HRDATA, 32'hDEADBEEF);

    // Byte write into an existing word
    idle(2);
    c0 = wr_commits;
    bus(1'b1, 1'b1, 32'h201, 3'd0, 32'h0000AA00);
    idle(1);
    chk("byte_be", 32'(last_be), 32'h2);
    chk("byte_commits", wr_commits - c0, 32'd1);
    bus(1'b1, 1'b0, 32'h200, 3'd2, 32'h0);
    idle(1);
    chk("byte_merge", HRDATA, 32'h1122AA44);

    // Illegal transfers: misaligned half, out of range, dword on a 32-bit bus
    idle(2);
    snap = sram[32'h100 >> 2];
    c0 = wr_commits;
    bus(1'b1, 1'b1, 32'h103, 3'd1, 32'h55550000);
    idle(3);
    chk("err_sram", sram[32'h100 >> 2], snap);
    chk("err_commits", wr_commits - c0, 32'd0);
    bus(1'b1, 1'b0, 32'h1000, 3'd2, 32'h0);
    idle(3);
    bus(1'b1, 1'b1, 32'h300, 3'd3, 32'hFFFFFFFF);
    idle(3);
    chk("err_commits2", wr_commits - c0, 32'd0);
    bus(1'b1, 1'b0, 32'h100, 3'd2, 32'h0);
    idle(1);

    // Back-to-back writes then reads
    c0 = wr_commits;
    for (int i = 0; i < 4; i++) bus(1'b1, 1'b1, 32'h140 + 32'(4*i), 3'd2, $urandom);
    for (int i = 0; i < 4; i++) bus(1'b1, 1'b0, 32'h140 + 32'(4*i), 3'd2, 32'h0);
    idle(2);
    chk("b2b_commits", wr_commits - c0, 32'd4);

    // Write followed by idle cycles commits once, on the first idle
    c0 = wr_commits;
    bus(1'b1, 1'b1, 32'h180, 3'd2, 32'h0BADF00D);
    idle(1);
    chk("idle_commit_first", wr_commits - c0, 32'd1);
    idle(3);
    chk("idle_commit_once", wr_commits - c0, 32'd1);

    // Reset while a write is pending
    old = ref_mem[32'h1C0 >> 2];
    bus(1'b1, 1'b1, 32'h1C0, 3'd2, 32'hCAFEF00D);
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HRESETn = 1'b0;
    #2;
    chk_reset_outputs("midreset");
    ref_mem[32'h1C0 >> 2] = old;
    dp_rd = 1'b0;
    dp_wr = 1'b0;
    err_phase = 0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    chk("reset_sram", sram[32'h1C0 >> 2], old);
    bus(1'b1, 1'b0, 32'h1C0, 3'd2, 32'h0);
    idle(1);
    chk("reset_old_data", HRDATA, old);

    // Random traffic over a small window so the buffer and forwarding are exercised
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        idle(1);
      end else begin
        w = (r < 60);
        sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a = 32'h300 + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        if ($urandom_range(0, 19) == 0) a = a + 32'h1000;
        bus(1'b1, w, a, sz, $urandom);
      end
    end
    idle(4);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
    chk("sram_final", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
